// File: rtl/ibc_ref_row_streamer.sv
// Captures one luma reference block from the inter reference cache and streams the
// 8x8 IBC window at the given offsets, one row per handshake, with edge replication.
module ibc_ref_row_streamer #(
    parameter int unsigned BIT_DEPTH            = 8,
    parameter int unsigned LUMA_REF_BLOCK_WIDTH = 16,
    parameter int unsigned LUMA_DIM_WDTH        = 4,
    parameter int unsigned OUT_BLK_WIDTH        = 8
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic                                                        valid_in,
    output logic                                                        idle_out,
    input  logic [BIT_DEPTH*LUMA_REF_BLOCK_WIDTH*LUMA_REF_BLOCK_WIDTH-1:0] luma_ref_block_in,
    input  logic [LUMA_DIM_WDTH-1:0]                                    block_x_offset_in,
    input  logic [LUMA_DIM_WDTH-1:0]                                    block_y_offset_in,
    output logic [BIT_DEPTH*OUT_BLK_WIDTH-1:0]                          row_data_out,
    output logic [2:0]                                                  row_idx_out,
    output logic                                                        row_last_out,
    output logic                                                        row_valid_out,
    input  logic                                                        row_ready_in,
    output logic [15:0]                                                 blk_count_out
);

    localparam int unsigned BLK_BITS = BIT_DEPTH * LUMA_REF_BLOCK_WIDTH * LUMA_REF_BLOCK_WIDTH;
    localparam int unsigned ROW_BITS = BIT_DEPTH * OUT_BLK_WIDTH;
    localparam int unsigned SUM_W    = LUMA_DIM_WDTH + 1;
    localparam int unsigned CNT_W    = 16;
    localparam logic [2:0]       LAST_ROW = 3'(OUT_BLK_WIDTH - 1);
    localparam logic [SUM_W-1:0] MAX_IDX  = SUM_W'(LUMA_REF_BLOCK_WIDTH - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [BLK_BITS-1:0]        r_blk;
    logic [LUMA_DIM_WDTH-1:0]   r_x_off;
    logic [LUMA_DIM_WDTH-1:0]   r_y_off;
    logic [2:0]                 r_row_cnt;
    logic [ROW_BITS-1:0]        r_row_data;
    logic                       r_idle;
    logic                       r_row_valid;
    logic                       r_row_last;
    logic [CNT_W-1:0]           r_blk_count;

    logic [2:0]                 w_cnt_nxt;
    logic [ROW_BITS-1:0]        w_data_nxt;
    logic [CNT_W-1:0]           w_blk_cnt_nxt;
    logic                       w_capture;
    logic                       w_handshake;

    logic [BLK_BITS-1:0]        w_src_block;
    logic [LUMA_DIM_WDTH-1:0]   w_src_x;
    logic [LUMA_DIM_WDTH-1:0]   w_src_y;
    logic [2:0]                 w_src_row;
    logic [SUM_W-1:0]           w_row_sum;
    logic [SUM_W-1:0]           w_row_clamp;
    logic [SUM_W-1:0]           w_col_sum   [OUT_BLK_WIDTH];
    logic [SUM_W-1:0]           w_col_clamp [OUT_BLK_WIDTH];
    logic [ROW_BITS-1:0]        w_row_next;

    function automatic int unsigned pix_lsb(input logic [SUM_W-1:0] row,
                                            input logic [SUM_W-1:0] col);
        return (32'(row) * LUMA_REF_BLOCK_WIDTH + 32'(col)) * BIT_DEPTH;
    endfunction

    assign w_handshake = r_row_valid & row_ready_in;

    // In IDLE the first row comes straight from the cache inputs; afterwards from the captured copy
    assign w_src_block = (r_state == S_IDLE) ? luma_ref_block_in : r_blk;
    assign w_src_x     = (r_state == S_IDLE) ? block_x_offset_in : r_x_off;
    assign w_src_y     = (r_state == S_IDLE) ? block_y_offset_in : r_y_off;
    assign w_src_row   = (r_state == S_IDLE) ? 3'd0 : r_row_cnt + 3'd1;

    // Sums are one bit wider than the offsets so clamping replaces wrap-around
    always_comb begin : row_extract
        w_row_sum   = {1'b0, w_src_y} + SUM_W'(w_src_row);
        w_row_clamp = (w_row_sum > MAX_IDX) ? MAX_IDX : w_row_sum;
        w_row_next  = '0;
        for (int c = 0; c < int'(OUT_BLK_WIDTH); c++) begin
            w_col_sum[c]   = {1'b0, w_src_x} + SUM_W'(c);
            w_col_clamp[c] = (w_col_sum[c] > MAX_IDX) ? MAX_IDX : w_col_sum[c];
            w_row_next[c*BIT_DEPTH +: BIT_DEPTH] =
                w_src_block[pix_lsb(w_row_clamp, w_col_clamp[c]) +: BIT_DEPTH];
        end
    end

    always_comb begin : next_state
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_row_cnt;
        w_data_nxt    = r_row_data;
        w_blk_cnt_nxt = r_blk_count;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 3'd0;
                    w_data_nxt  = w_row_next;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_handshake) begin
                    if (r_row_cnt == LAST_ROW) begin
                        w_state_nxt   = S_IDLE;
                        w_cnt_nxt     = 3'd0;
                        w_blk_cnt_nxt = r_blk_count + CNT_W'(1);
                    end else begin
                        w_cnt_nxt  = r_row_cnt + 3'd1;
                        w_data_nxt = w_row_next;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        if (!reset) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= 3'd0;
            r_row_data  <= '0;
            r_idle      <= 1'b1;
            r_row_valid <= 1'b0;
            r_row_last  <= 1'b0;
            r_blk_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_cnt   <= w_cnt_nxt;
            r_row_data  <= w_data_nxt;
            r_idle      <= (w_state_nxt == S_IDLE);
            r_row_valid <= (w_state_nxt == S_STREAM);
            r_row_last  <= (w_state_nxt == S_STREAM) && (w_cnt_nxt == LAST_ROW);
            r_blk_count <= w_blk_cnt_nxt;
        end
    end

    // Block store and offsets are only read while streaming, so they carry no reset
    always_ff @(posedge clk) begin : blk_store
        if (w_capture) begin
            r_blk   <= luma_ref_block_in;
            r_x_off <= block_x_offset_in;
            r_y_off <= block_y_offset_in;
        end
    end

    assign idle_out      = r_idle;
    assign row_valid_out = r_row_valid;
    assign row_last_out  = r_row_last;
    assign row_idx_out   = r_row_cnt;
    assign row_data_out  = r_row_data;
    assign blk_count_out = r_blk_count;

endmodule
